// File: rtl/snake_vga_pkg.sv
// ============================================================================
// snake_vga_pkg : shared widths, colours and build-FSM states for the
//                 snake tile compositor.
// Revision 1.0
// ============================================================================
`default_nettype none

package snake_vga_pkg;
    localparam int                 COLOR_W         = 12;
    localparam logic [31:0]        INVALID_COORD   = 32'hFFFF_FFFF;
    localparam logic [COLOR_W-1:0] DEF_SNAKE_COLOR = 12'h0F0;
    localparam logic [COLOR_W-1:0] DEF_FOOD_COLOR  = 12'hF00;
    localparam logic [COLOR_W-1:0] GRID_COLOR      = 12'h444;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FILL  = 2'd2,
        SWAP  = 2'd3
    } build_state_e;
endpackage

`default_nettype wire

// File: rtl/tile_occupancy_grid.sv
// ============================================================================
// tile_occupancy_grid : double-banked tile occupancy bitmap with build-bank
//                       clear/set and a combinational display-bank read.
// Revision 1.0
// ============================================================================
`default_nettype none

module tile_occupancy_grid #(
    parameter int CELLS = 140,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    output logic             set_was,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_bit,
    input  logic             toggle
);
    localparam logic [IDX_W-1:0] LIMIT = IDX_W'(CELLS);

    logic [CELLS-1:0] bank0_q, bank0_d;
    logic [CELLS-1:0] bank1_q, bank1_d;
    logic             disp_q, disp_d;

    // disp_q selects the displayed bank; the other one is the build bank.
    always_comb begin
        set_was = 1'b0;
        if (set_idx < LIMIT)
            set_was = disp_q ? bank0_q[set_idx] : bank1_q[set_idx];
        rd_bit = 1'b0;
        if (rd_idx < LIMIT)
            rd_bit = disp_q ? bank1_q[rd_idx] : bank0_q[rd_idx];
    end

    always_comb begin
        bank0_d = bank0_q;
        bank1_d = bank1_q;
        disp_d  = disp_q;
        if (clear) begin
            if (disp_q) bank0_d = '0;
            else        bank1_d = '0;
        end
        if (set_en && (set_idx < LIMIT)) begin
            if (disp_q) bank0_d[set_idx] = 1'b1;
            else        bank1_d[set_idx] = 1'b1;
        end
        if (toggle)
            disp_d = ~disp_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank0_q <= '0;
            bank1_q <= '0;
            disp_q  <= 1'b0;
        end else begin
            bank0_q <= bank0_d;
            bank1_q <= bank1_d;
            disp_q  <= disp_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/snake_tile_compositor.sv
// ============================================================================
// snake_tile_compositor : builds a tile grid per frame, composites snake and
//                         food over the background. Option: GRID_LINES_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module snake_tile_compositor
    import snake_vga_pkg::*;
#(
    parameter int                 MAX_SEGMENTS = 100,
    parameter int                 BOARD_COLS   = 14,
    parameter int                 BOARD_ROWS   = 10,
    parameter int                 TILE_SIZE    = 40,
    parameter int                 BOARD_X0     = 48,
    parameter int                 BOARD_Y0     = 48,
    parameter logic [COLOR_W-1:0] SNAKE_COLOR  = DEF_SNAKE_COLOR,
    parameter logic [COLOR_W-1:0] FOOD_COLOR   = DEF_FOOD_COLOR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      screen_end,
    input  logic                      pix_valid,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic [COLOR_W-1:0]        bg_color,
    input  logic [32*MAX_SEGMENTS-1:0] x_values,
    input  logic [32*MAX_SEGMENTS-1:0] y_values,
    input  logic [31:0]               food_x,
    input  logic [31:0]               food_y,
    output logic                      out_valid,
    output logic [COLOR_W-1:0]        color_out,
    output logic                      busy,
    output logic [7:0]                seg_count,
    output logic                      self_hit
);
    localparam int                CELLS     = BOARD_COLS * BOARD_ROWS;
    localparam int                GIDX_W    = $clog2(CELLS + 1);
    localparam int                SIDX_W    = (MAX_SEGMENTS > 1) ? $clog2(MAX_SEGMENTS) : 1;
    localparam logic [SIDX_W-1:0] LAST_SLOT = SIDX_W'(MAX_SEGMENTS - 1);
    localparam logic [9:0]        X0        = 10'(BOARD_X0);
    localparam logic [9:0]        Y0        = 10'(BOARD_Y0);
    localparam logic [9:0]        TILE      = 10'(TILE_SIZE);
    localparam logic [9:0]        BW        = 10'(BOARD_COLS * TILE_SIZE);
    localparam logic [9:0]        BH        = 10'(BOARD_ROWS * TILE_SIZE);

    build_state_e      state_q, state_d;
    logic [SIDX_W-1:0] slot_q, slot_d;
    logic [7:0]        count_q, count_d, seg_count_q, seg_count_d;
    logic              hit_q, hit_d, self_hit_q, self_hit_d;
    logic              food_valid_q, food_valid_d;
    logic [9:0]        food_col_q, food_col_d, food_row_q, food_row_d;

    logic [31:0]       w_seg_x, w_seg_y;
    logic              w_slot_ok, w_set_was, w_rd_bit;
    logic [GIDX_W-1:0] w_set_idx, w_rd_idx;

    assign w_seg_x   = x_values[32*int'(slot_q) +: 32];
    assign w_seg_y   = y_values[32*int'(slot_q) +: 32];
    assign w_slot_ok = (w_seg_x != INVALID_COORD) && (w_seg_y != INVALID_COORD) &&
                       (w_seg_x < 32'(BOARD_COLS)) && (w_seg_y < 32'(BOARD_ROWS));
    assign w_set_idx = GIDX_W'(w_seg_y) * GIDX_W'(BOARD_COLS) + GIDX_W'(w_seg_x);

    tile_occupancy_grid #(
        .CELLS (CELLS),
        .IDX_W (GIDX_W)
    ) u_grid (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == CLEAR),
        .set_en  ((state_q == FILL) && w_slot_ok),
        .set_idx (w_set_idx),
        .set_was (w_set_was),
        .rd_idx  (w_rd_idx),
        .rd_bit  (w_rd_bit),
        .toggle  (state_q == SWAP)
    );

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        count_d      = count_q;
        hit_d        = hit_q;
        seg_count_d  = seg_count_q;
        self_hit_d   = self_hit_q;
        food_valid_d = food_valid_q;
        food_col_d   = food_col_q;
        food_row_d   = food_row_q;
        case (state_q)
            IDLE: if (screen_end) state_d = CLEAR;
            CLEAR: begin
                slot_d  = '0;
                count_d = '0;
                hit_d   = 1'b0;
                state_d = FILL;
            end
            FILL: begin
                if (w_slot_ok) begin
                    if (w_set_was) hit_d = 1'b1;
                    if (count_q != 8'hFF) count_d = count_q + 8'd1;
                end
                if (slot_q == LAST_SLOT) state_d = SWAP;
                else                     slot_d  = slot_q + 1'b1;
            end
            SWAP: begin
                seg_count_d  = count_q;
                self_hit_d   = hit_q;
                food_valid_d = (food_x < 32'(BOARD_COLS)) && (food_y < 32'(BOARD_ROWS));
                food_col_d   = food_x[9:0];
                food_row_d   = food_y[9:0];
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            count_q      <= '0;
            hit_q        <= 1'b0;
            seg_count_q  <= '0;
            self_hit_q   <= 1'b0;
            food_valid_q <= 1'b0;
            food_col_q   <= '0;
            food_row_q   <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            count_q      <= count_d;
            hit_q        <= hit_d;
            seg_count_q  <= seg_count_d;
            self_hit_q   <= self_hit_d;
            food_valid_q <= food_valid_d;
            food_col_q   <= food_col_d;
            food_row_q   <= food_row_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign seg_count = seg_count_q;
    assign self_hit  = self_hit_q;

    // Stage 1: board-relative tile coordinates.
    logic               s1_valid_q, s1_valid_d, s1_in_q, s1_in_d;
    logic [9:0]         s1_col_q, s1_col_d, s1_row_q, s1_row_d, w_rx, w_ry;
    logic [COLOR_W-1:0] s1_bg_q, s1_bg_d, color_q, color_d;
    logic               valid2_q;
`ifdef GRID_LINES_EN
    logic               s1_edge_q, s1_edge_d;
`endif

    always_comb begin
        w_rx       = x - X0;
        w_ry       = y - Y0;
        s1_valid_d = pix_valid;
        s1_in_d    = (x >= X0) && (y >= Y0) && (w_rx < BW) && (w_ry < BH);
        s1_col_d   = w_rx / TILE;
        s1_row_d   = w_ry / TILE;
        s1_bg_d    = bg_color;
`ifdef GRID_LINES_EN
        s1_edge_d  = ((w_rx % TILE) == 10'd0) || ((w_ry % TILE) == 10'd0);
`endif
    end

    // Stage 2: food beats snake beats background.
    assign w_rd_idx = GIDX_W'(s1_row_q) * GIDX_W'(BOARD_COLS) + GIDX_W'(s1_col_q);

    always_comb begin
        color_d = '0;
        if (s1_valid_q) begin
            color_d = s1_bg_q;
            if (s1_in_q) begin
                if (food_valid_q && (s1_col_q == food_col_q) && (s1_row_q == food_row_q))
                    color_d = FOOD_COLOR;
                else if (w_rd_bit)
                    color_d = SNAKE_COLOR;
`ifdef GRID_LINES_EN
                else if (s1_edge_q)
                    color_d = GRID_COLOR;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_in_q    <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_bg_q    <= '0;
`ifdef GRID_LINES_EN
            s1_edge_q  <= 1'b0;
`endif
            valid2_q   <= 1'b0;
            color_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_in_q    <= s1_in_d;
            s1_col_q   <= s1_col_d;
            s1_row_q   <= s1_row_d;
            s1_bg_q    <= s1_bg_d;
`ifdef GRID_LINES_EN
            s1_edge_q  <= s1_edge_d;
`endif
            valid2_q   <= s1_valid_q;
            color_q    <= color_d;
        end
    end

    assign out_valid = valid2_q;
    assign color_out = color_q;
endmodule

`default_nettype wire

// File: tb/tb_snake_tile_compositor.sv
// ============================================================================
// tb_snake_tile_compositor : directed pixel vectors around three grid builds.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_snake_tile_compositor;
    localparam int MAXS = 100;
    localparam logic [11:0] SNK = 12'h0F0;
    localparam logic [11:0] FD  = 12'hF00;

    logic              clk = 1'b0;
    logic              reset;
    logic              screen_end;
    logic              pix_valid;
    logic [9:0]        x, y;
    logic [11:0]       bg_color;
    logic [32*MAXS-1:0] x_values, y_values;
    logic [31:0]       food_x, food_y;
    logic              out_valid, busy, self_hit;
    logic [11:0]       color_out;
    logic [7:0]        seg_count;

    always #5 clk = ~clk;

    snake_tile_compositor dut (
        .clk        (clk),
        .reset      (reset),
        .screen_end (screen_end),
        .pix_valid  (pix_valid),
        .x          (x),
        .y          (y),
        .bg_color   (bg_color),
        .x_values   (x_values),
        .y_values   (y_values),
        .food_x     (food_x),
        .food_y     (food_y),
        .out_valid  (out_valid),
        .color_out  (color_out),
        .busy       (busy),
        .seg_count  (seg_count),
        .self_hit   (self_hit)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          phase;
        logic [9:0]  px, py;
        logic [11:0] bg;
        logic        pv;
        logic        ev;
        logic [11:0] ec;
    } vec_t;
    vec_t vt[$];

    function automatic void add(input int ph, input int px, input int py, input logic [11:0] bg,
                                input logic pv, input logic ev, input logic [11:0] ec);
        vec_t v;
        v.phase = ph; v.px = 10'(px); v.py = 10'(py); v.bg = bg;
        v.pv = pv; v.ev = ev; v.ec = ec;
        vt.push_back(v);
    endfunction

    task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic [11:0] b,
                       input logic pv, output logic ov, output logic [11:0] oc);
        @(negedge clk);
        x = px; y = py; bg_color = b; pix_valid = pv;
        @(posedge clk);
        @(posedge clk);
        #1;
        ov = out_valid;
        oc = color_out;
    endtask

    task automatic run_phase(input int ph);
        logic        ov;
        logic [11:0] oc;
        foreach (vt[i]) begin
            if (vt[i].phase == ph) begin
                pix(vt[i].px, vt[i].py, vt[i].bg, vt[i].pv, ov, oc);
                check($sformatf("ph%0d_vec%0d_valid(%0d,%0d)", ph, i, vt[i].px, vt[i].py), 32'(ov), 32'(vt[i].ev));
                check($sformatf("ph%0d_vec%0d_color(%0d,%0d)", ph, i, vt[i].px, vt[i].py), 32'(oc), 32'(vt[i].ec));
            end
        end
    endtask

    task automatic set_seg(input int i, input logic [31:0] sx, input logic [31:0] sy);
        x_values[32*i +: 32] = sx;
        y_values[32*i +: 32] = sy;
    endtask

    // Counts busy cycles of one build; optionally re-pulses screen_end mid-FILL.
    task automatic run_build(input bit dbl, output int cyc, output int late);
        @(negedge clk);
        screen_end = 1'b1;
        @(negedge clk);
        screen_end = 1'b0;
        cyc = 0;
        while (busy && cyc < 500) begin
            cyc++;
            screen_end = (dbl && cyc == 20);
            @(negedge clk);
        end
        screen_end = 1'b0;
        late = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) late++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, late;
        logic        ov;
        logic [11:0] oc;

        // Phase 1: segments (0,0),(1,0), food out of range.
        add(1,  48,  48, 12'h123, 1'b1, 1'b1, SNK);
        add(1,  87,  87, 12'h123, 1'b1, 1'b1, SNK);
        add(1,  88,  48, 12'h123, 1'b1, 1'b1, SNK);
        add(1, 128,  48, 12'h5A5, 1'b1, 1'b1, 12'h5A5);
        add(1, 208,  48, 12'h321, 1'b1, 1'b1, 12'h321);
        add(1,  47,  48, 12'h777, 1'b1, 1'b1, 12'h777);
        add(1,  48,  88, 12'h888, 1'b1, 1'b1, 12'h888);
        add(1,  48,  48, 12'h123, 1'b0, 1'b0, 12'h000);
        // Phase 2: duplicated (3,3), food on segment (1,0), last slot (5,5).
        add(2,  88,  48, 12'h111, 1'b1, 1'b1, FD);
        add(2, 127,  87, 12'h111, 1'b1, 1'b1, FD);
        add(2, 168, 168, 12'h111, 1'b1, 1'b1, SNK);
        add(2,  48,  48, 12'h222, 1'b1, 1'b1, 12'h222);
        add(2, 128,  48, 12'h333, 1'b1, 1'b1, 12'h333);
        add(2, 287, 248, 12'h111, 1'b1, 1'b1, SNK);
        add(2, 288, 248, 12'h444, 1'b1, 1'b1, 12'h444);
        // Phase 3: (2,2),(0,9), no food; reuses the bank that held phase 1.
        add(3, 128, 128, 12'h999, 1'b1, 1'b1, SNK);
        add(3,  48, 408, 12'h999, 1'b1, 1'b1, SNK);
        add(3,  48, 447, 12'h999, 1'b1, 1'b1, SNK);
        add(3,  48, 448, 12'hAAA, 1'b1, 1'b1, 12'hAAA);
        add(3, 608, 368, 12'hBBB, 1'b1, 1'b1, 12'hBBB);
        add(3, 607, 368, 12'hCCC, 1'b1, 1'b1, 12'hCCC);
        add(3,  48,  48, 12'hDDD, 1'b1, 1'b1, 12'hDDD);
        add(3,  88,  48, 12'hEEE, 1'b1, 1'b1, 12'hEEE);
        add(3, 168, 168, 12'h0AB, 1'b1, 1'b1, 12'h0AB);

        reset = 1'b0; screen_end = 1'b0; pix_valid = 1'b0;
        x = '0; y = '0; bg_color = '0;
        x_values = '1; y_values = '1;
        food_x = '1; food_y = '1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_color_out", 32'(color_out), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_seg_count", 32'(seg_count), 32'd0);
        check("rst_self_hit",  32'(self_hit),  32'd0);
        reset = 1'b1;

        pix(10'd60, 10'd60, 12'hABC, 1'b1, ov, oc);
        check("idle_valid", 32'(ov), 32'd1);
        check("idle_color", 32'(oc), 32'hABC);
        check("idle_busy",  32'(busy), 32'd0);

        set_seg(0, 32'd0, 32'd0);
        set_seg(1, 32'd1, 32'd0);
        food_x = 32'd20; food_y = 32'd0;
        run_build(1'b0, cyc, late);
        check("b1_busy_cycles", 32'(cyc), 32'(MAXS + 2));
        check("b1_idle_after",  32'(late), 32'd0);
        check("b1_seg_count",   32'(seg_count), 32'd2);
        check("b1_self_hit",    32'(self_hit),  32'd0);
        run_phase(1);

        x_values = '1; y_values = '1;
        set_seg(0, 32'd3, 32'd3);
        set_seg(1, 32'd3, 32'd3);
        set_seg(2, 32'd1, 32'd0);
        set_seg(3, 32'hFFFF_FFFF, 32'd2);
        set_seg(4, 32'd14, 32'd0);
        set_seg(MAXS - 1, 32'd5, 32'd5);
        food_x = 32'd1; food_y = 32'd0;
        run_build(1'b0, cyc, late);
        check("b2_busy_cycles", 32'(cyc), 32'(MAXS + 2));
        check("b2_seg_count",   32'(seg_count), 32'd4);
        check("b2_self_hit",    32'(self_hit),  32'd1);
        run_phase(2);

        x_values = '1; y_values = '1;
        set_seg(0, 32'd2, 32'd2);
        set_seg(1, 32'd0, 32'd9);
        food_x = 32'hFFFF_FFFF; food_y = 32'd0;
        run_build(1'b1, cyc, late);
        check("b3_busy_cycles", 32'(cyc), 32'(MAXS + 2));
        check("b3_idle_after",  32'(late), 32'd0);
        check("b3_seg_count",   32'(seg_count), 32'd2);
        check("b3_self_hit",    32'(self_hit),  32'd0);
        run_phase(3);

        // Asynchronous reset in the middle of FILL.
        @(negedge clk);
        x = 10'd128; y = 10'd128; bg_color = 12'hABC; pix_valid = 1'b1;
        @(negedge clk);
        screen_end = 1'b1;
        @(negedge clk);
        screen_end = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_busy",      32'(busy),      32'd1);
        check("mid_color",     32'(color_out), 32'(SNK));
        check("mid_seg_count", 32'(seg_count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_color",     32'(color_out), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_seg_count", 32'(seg_count), 32'd0);
        check("arst_self_hit",  32'(self_hit),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        pix(10'd128, 10'd128, 12'hABC, 1'b1, ov, oc);
        check("post_rst_valid", 32'(ov), 32'd1);
        check("post_rst_color", 32'(oc), 32'hABC);
        pix(10'd48, 10'd408, 12'h5C5, 1'b1, ov, oc);
        check("post_rst_color2", 32'(oc), 32'h5C5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/snake_tile_compositor.md
Name: snake_tile_compositor

Overview:
- Parametrised successor of the single-frame snake/food overlay logic. Renders snake segments and food over the background stream.
- On each frame boundary, builds a double-banked tile-occupancy grid from the packed segment buses, one segment per cycle. During the active frame, a fixed-latency pixel pipeline composites from the stable bank.
- Sits between VGATimingGenerator/background palette RAM and the VGA colour outputs.
- Adds self-collision detection and a valid-segment count that the old overlay lacked.

Parameters:
- MAX_SEGMENTS, 100: segment slots on x_values/y_values (32 bits each).
- BOARD_COLS, 14: tile columns.
- BOARD_ROWS, 10: tile rows.
- TILE_SIZE, 40: tile edge in pixels.
- BOARD_X0, 48: board left edge in pixels.
- BOARD_Y0, 48: board top edge in pixels.
- SNAKE_COLOR, 12'h0F0: snake tile colour.
- FOOD_COLOR, 12'hF00: food tile colour.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- screen_end  in  1  one-cycle pulse between frames; starts a grid build
- pix_valid  in  1  active-video qualifier for x/y/bg_color
- x  in  10  pixel column
- y  in  10  pixel row
- bg_color  in  12  background colour for this pixel
- x_values  in  32*MAX_SEGMENTS  packed segment tile columns; 32'hFFFFFFFF = empty slot
- y_values  in  32*MAX_SEGMENTS  packed segment tile rows; 32'hFFFFFFFF = empty slot
- food_x  in  32  food tile column
- food_y  in  32  food tile row
- out_valid  out  1  pix_valid delayed 2 cycles
- color_out  out  12  composited colour; 0 when out_valid low
- busy  out  1  grid build in progress
- seg_count  out  8  valid segments counted in last completed build
- self_hit  out  1  last completed build found two segments on one tile

Behaviour:
- Reset (asynchronous, reset low):
  - both grid banks cleared; display bank = 0; FSM IDLE
  - out_valid=0, color_out=0, busy=0, seg_count=0, self_hit=0
  - latched food invalid (no food drawn)
- FSM states:
  - IDLE: on screen_end -> CLEAR.
  - CLEAR: 1 cycle, zero all cells of the build bank (the bank not displayed); index i=0, count=0, hit=0 -> FILL.
  - FILL: 1 cycle per slot i=0..MAX_SEGMENTS-1.
    - Slot valid iff x!=all-ones, y!=all-ones, x<BOARD_COLS, y<BOARD_ROWS; invalid or out-of-range slots are skipped without stopping.
    - For a valid slot: if its cell is already set, hit<=1; then set the cell and increment count (saturates at 255).
    - After i=MAX_SEGMENTS-1 -> SWAP.
  - SWAP: 1 cycle.
    - Toggle display bank.
    - Commit seg_count<=count and self_hit<=hit.
    - Latch food_x/food_y; latched food is valid iff in range.
    - -> IDLE.
- busy is high in CLEAR, FILL and SWAP. Total build = MAX_SEGMENTS+2 cycles.
- screen_end while busy is ignored; the build in progress completes normally.
- Segment and food inputs are sampled only during FILL/SWAP. The display bank never changes mid-frame except at SWAP, which occurs in blanking.
- Pixel pipeline, latency exactly 2 cycles, no stalls:
  - Stage 1: rx = x-BOARD_X0, ry = y-BOARD_Y0. in_board iff x>=BOARD_X0, y>=BOARD_Y0, rx<BOARD_COLS*TILE_SIZE, ry<BOARD_ROWS*TILE_SIZE. col = rx/TILE_SIZE, row = ry/TILE_SIZE. Register these with bg_color and pix_valid.
  - Stage 2: priority is food tile (latched, valid, col/row match) > snake cell set in display bank > bg_color. Pixels outside the board always get bg_color.
  - color_out=0 whenever the stage-2 valid bit is 0.
- Boundary cases:
  - Pixel at rx = BOARD_COLS*TILE_SIZE is outside the board.
  - Food and snake on the same tile: food colour wins.
  - reset asserted mid-FILL: build is abandoned and all state returns to reset values.

Optional Feature:
- GRID_LINES_EN.
- Defined: in-board pixels with rx%TILE_SIZE==0 or ry%TILE_SIZE==0 and no food/snake hit output 12'h444. Latency unchanged.
- Undefined: no grid lines; behaviour exactly as above.

Decomposition:
- Package snake_vga_pkg holds:
  - COLOR_W=12 and INVALID_COORD=32'hFFFFFFFF
  - default SNAKE/FOOD/GRID colours
  - FSM state enum {IDLE, CLEAR, FILL, SWAP}
- Sub-module tile_occupancy_grid: two banks of BOARD_COLS*BOARD_ROWS bits, with:
  - bulk-clear of the build bank
  - a single set port with read-before-set, used for the hit check
  - a combinational read port on the display bank
  - a bank toggle

Test Plan:
- Reset release, no screen_end; drive pix_valid=1, x=60, y=60, bg=12'hABC -> 2 cycles later out_valid=1, color_out=12'hABC, busy=0.
- Segments (0,0),(1,0), rest all-ones; pulse screen_end -> busy high exactly MAX_SEGMENTS+2 cycles, then seg_count=2, self_hit=0. Pixel (48,48) -> 12'h0F0; pixel (128,48) -> bg.
- Segments (3,3),(3,3) -> self_hit=1, seg_count=2. Next build with distinct segments -> self_hit=0.
- Food (1,0) overlapping segment (1,0) -> pixel (88,48) gives 12'hF00. Food (20,0) out of range -> no food drawn.
- Second screen_end pulse during FILL -> ignored; exactly one SWAP, and bank toggles once.
- reset low mid-FILL -> busy=0, color_out=0, seg_count=0 immediately (asynchronous). Old display contents cleared.
